// File: rtl/iod_delay_line_ctrl.sv
// Delay-line sequencer for a bank of PolarFire IOD lanes: MOVE/DIRECTION/LOAD pulse generation
// with per-lane shadow taps. Define IOD_DLY_CTRL_SOFT_LIMIT_EN to stop moves at the tap limits.
module iod_delay_line_ctrl #(
    parameter int NUM_LANES = 16,
    parameter int TAP_W     = 7,
    parameter int MAX_TAP   = 127,
    parameter int LOAD_TAP  = 1,
    parameter int MOVE_GAP  = 4,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                 FAB_CLK,
    input  logic                 ARST,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [1:0]           REQ_OP,
    input  logic [LANE_W-1:0]    REQ_LANE,
    input  logic                 REQ_DIR,
    input  logic [TAP_W-1:0]     REQ_STEPS,
    output logic                 DONE,
    output logic [1:0]           DONE_STATUS,
    output logic [TAP_W-1:0]     TAP_POS,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE
);
`ifdef IOD_DLY_CTRL_SOFT_LIMIT_EN
    localparam bit SOFT_LIMIT = 1'b1;
`else
    localparam bit SOFT_LIMIT = 1'b0;
`endif
    localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MOVE_GAP - 1);
    localparam logic [TAP_W-1:0]  TAP_MAX  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0]  TAP_LOAD = TAP_W'(LOAD_TAP);
    localparam logic [LANE_W:0]   LANES    = (LANE_W + 1)'(NUM_LANES);
    localparam logic [1:0] OP_MOVE = 2'b00, OP_LOAD = 2'b01, OP_LOAD_ALL = 2'b10;
    localparam logic [1:0] ST_OK = 2'b00, ST_SOFT = 2'b01, ST_RANGE = 2'b10, ST_BAD = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, MOVE, GAP, LOAD, LWAIT, FIN} state_t;

    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [LANE_W-1:0] lane);
        lane_mask = '0;
        lane_mask[lane] = 1'b1;
    endfunction

    // Saturating single-tap step: the shadow never wraps.
    function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap, input logic dir);
        if (dir) tap_step = (tap == TAP_MAX) ? tap : tap + 1'b1;
        else     tap_step = (tap == '0) ? tap : tap - 1'b1;
    endfunction

    function automatic logic at_limit(input logic [TAP_W-1:0] tap, input logic dir);
        at_limit = SOFT_LIMIT && (dir ? (tap == TAP_MAX) : (tap == '0));
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           status_q, status_d;
    logic [1:0]           op_q;
    logic [LANE_W-1:0]    lane_q;
    logic                 dir_q;
    logic [TAP_W-1:0]     rem_q;
    logic [GAP_W-1:0]     gap_q;
    logic [TAP_W-1:0]     tap_q [NUM_LANES];

    logic                 accept, bad_req, oor, check_edge;
    logic [TAP_W-1:0]     cur_tap, tap_after, fin_tap;
    logic [LANE_W-1:0]    sel_lane;
    logic [1:0]           sel_op;
    logic                 sel_dir;
    logic                 ready_d, done_d;
    logic [1:0]           status_o_d;
    logic [TAP_W-1:0]     tap_pos_d;
    logic [NUM_LANES-1:0] move_d, dir_d, load_d;

    assign accept     = (state_q == IDLE) && REQ_VALID && REQ_READY;
    assign bad_req    = (REQ_OP == 2'b11) || ((REQ_OP != OP_LOAD_ALL) && ({1'b0, REQ_LANE} >= LANES));
    assign cur_tap    = tap_q[lane_q];
    assign oor        = DELAY_LINE_OUT_OF_RANGE[lane_q];
    assign check_edge = (state_q == GAP) && (gap_q == '0);
    assign tap_after  = (check_edge && !oor) ? tap_step(cur_tap, dir_q) : cur_tap;
    assign fin_tap    = (state_q == GAP) ? tap_after :
                        ((state_q == LWAIT) && (op_q == OP_LOAD_ALL)) ? tap_q[0] : cur_tap;

    // In IDLE the request fields are not latched yet, so outputs for the first state use the inputs.
    assign sel_lane = (state_q == IDLE) ? REQ_LANE : lane_q;
    assign sel_op   = (state_q == IDLE) ? REQ_OP : op_q;
    assign sel_dir  = (state_q == IDLE) ? REQ_DIR : dir_q;

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q              <= IDLE;
            status_q             <= ST_OK;
            rem_q                <= '0;
            gap_q                <= '0;
            REQ_READY            <= 1'b0;
            DONE                 <= 1'b0;
            DONE_STATUS          <= '0;
            TAP_POS              <= '0;
            DELAY_LINE_MOVE      <= '0;
            DELAY_LINE_DIRECTION <= '0;
            DELAY_LINE_LOAD      <= '0;
        end else begin
            state_q              <= state_d;
            status_q             <= status_d;
            REQ_READY            <= ready_d;
            DONE                 <= done_d;
            DONE_STATUS          <= status_o_d;
            TAP_POS              <= tap_pos_d;
            DELAY_LINE_MOVE      <= move_d;
            DELAY_LINE_DIRECTION <= dir_d;
            DELAY_LINE_LOAD      <= load_d;
            if (accept) rem_q <= REQ_STEPS;
            else if (state_q == MOVE) rem_q <= rem_q - 1'b1;
            if (state_q == MOVE || state_q == LOAD) gap_q <= GAP_LAST;
            else if ((state_q == GAP || state_q == LWAIT) && gap_q != '0) gap_q <= gap_q - 1'b1;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (accept) begin
            op_q   <= REQ_OP;
            lane_q <= REQ_LANE;
            dir_q  <= REQ_DIR;
        end
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= TAP_LOAD;
        end else if (state_q == LOAD) begin
            if (op_q == OP_LOAD_ALL) begin
                for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= TAP_LOAD;
            end else begin
                tap_q[lane_q] <= TAP_LOAD;
            end
        end else if (check_edge && !oor) begin
            tap_q[lane_q] <= tap_after;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            IDLE: if (accept) begin
                status_d = ST_OK;
                if (bad_req) begin
                    state_d  = FIN;
                    status_d = ST_BAD;
                end else if (REQ_OP == OP_MOVE) state_d = SETUP;
                else state_d = LOAD;
            end
            SETUP: begin
                if (rem_q == '0) state_d = FIN;
                else if (at_limit(cur_tap, dir_q)) begin
                    state_d  = FIN;
                    status_d = ST_SOFT;
                end else state_d = MOVE;
            end
            MOVE: state_d = GAP;
            // The range flag is judged only in the last gap cycle, once the IOD has settled.
            GAP: if (gap_q == '0) begin
                if (oor) begin
                    state_d  = FIN;
                    status_d = ST_RANGE;
                end else if (rem_q == '0) state_d = FIN;
                else if (at_limit(tap_after, dir_q)) begin
                    state_d  = FIN;
                    status_d = ST_SOFT;
                end else state_d = MOVE;
            end
            LOAD:  state_d = LWAIT;
            LWAIT: if (gap_q == '0) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d    = (state_d == IDLE);
        done_d     = 1'b0;
        status_o_d = '0;
        tap_pos_d  = '0;
        move_d     = '0;
        dir_d      = '0;
        load_d     = '0;
        case (state_d)
            SETUP, GAP: dir_d = sel_dir ? lane_mask(sel_lane) : '0;
            MOVE: begin
                move_d = lane_mask(sel_lane);
                dir_d  = sel_dir ? lane_mask(sel_lane) : '0;
            end
            LOAD: load_d = (sel_op == OP_LOAD_ALL) ? '1 : lane_mask(sel_lane);
            FIN: begin
                done_d     = 1'b1;
                status_o_d = status_d;
                tap_pos_d  = (status_d == ST_BAD) ? '0 : fin_tap;
            end
            default: ;
        endcase
    end
endmodule
